// File: rtl/ram_2p_param.sv
// ram_2p_param: simple dual-port RAM, one write and one read port.
// Bit write mask, 1/2-cycle read latency, collision mode, clear engine.
module ram_2p_param #(
    parameter int unsigned      DEPTH          = 16,
    parameter int unsigned      WIDTH          = 6,
    parameter int unsigned      RD_LATENCY     = 1,
    parameter bit               WRITE_FIRST    = 1'b1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0,
    localparam int unsigned     ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write,
    input  logic [WIDTH-1:0]  datain,
    input  logic [WIDTH-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic              clear,
    output logic [WIDTH-1:0]  dataout,
    output logic              rvalid,
    output logic              busy,
    output logic              addr_err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [DEPTH*WIDTH-1:0] mem_unit;
    logic [0:0]             state;
    logic [ADDR_W-1:0]      cnt;

    logic             accept;
    logic             wr_ok;
    logic             rd_ok;
    logic             wr_en;
    logic             rd_en;
    logic             err;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_word;

    // A request arriving with clear is dropped: the memory is about to be wiped.
    assign busy   = (state == CLEAR);
    assign accept = !busy && !clear;
    assign wr_ok  = {1'b0, addr_w} < LIMIT;
    assign rd_ok  = {1'b0, addr_r} < LIMIT;
    assign wr_en  = accept && write && wr_ok;
    assign rd_en  = accept && read;
    assign err    = accept && ((write && !wr_ok) || (read && !rd_ok));

    // Fetch the current words at both addresses.
    always_comb begin
        wr_old = '0;
        rd_old = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (addr_w == ADDR_W'(k)) wr_old = mem_unit[k*WIDTH +: WIDTH];
            if (addr_r == ADDR_W'(k)) rd_old = mem_unit[k*WIDTH +: WIDTH];
        end
    end

    assign wr_word = (datain & wmask) | (wr_old & ~wmask);

    // Read data with collision bypass; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            if (WRITE_FIRST && wr_en && (addr_w == addr_r)) rd_word = wr_word;
            else                                            rd_word = rd_old;
        end
    end

    // Clear-engine sequencer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (clear) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage update from the clear engine or the write port; untouched by reset.
    always_ff @(posedge clock) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (busy && (cnt == ADDR_W'(k)))
                mem_unit[k*WIDTH +: WIDTH] <= INIT_VALUE;
            else if (wr_en && (addr_w == ADDR_W'(k)))
                mem_unit[k*WIDTH +: WIDTH] <= wr_word;
        end
    end

    // Out-of-range flag, aligned with the sampling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) addr_err <= 1'b0;
        else          addr_err <= err;
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic             s1_valid;
            logic [WIDTH-1:0] s1_data;

            // Two-stage read pipeline; an in-flight read is dropped if a clear starts.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rvalid   <= 1'b0;
                    dataout  <= '0;
                end else begin
                    s1_valid <= rd_en;
                    if (rd_en) s1_data <= rd_word;
                    rvalid <= s1_valid && accept;
                    if (s1_valid && accept) dataout <= s1_data;
                end
            end
        end else begin : g_lat1
            // Single-stage read: output register loads on the sampling edge.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rvalid  <= 1'b0;
                    dataout <= '0;
                end else begin
                    rvalid <= rd_en;
                    if (rd_en) dataout <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_2p_param.sv
// tb_ram_2p_param: two RAM configurations against an array-based model.
// Random traffic plus directed clear, collision and range cases.
module tb_ram_2p_param;

    localparam logic [5:0] INIT0 = 6'd5;
    localparam logic [5:0] INIT1 = 6'h2A;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       write[2];
    logic       read[2];
    logic       clear[2];
    logic [5:0] datain[2];
    logic [5:0] wmask[2];
    logic [5:0] dataout[2];
    logic [3:0] addr_w[2];
    logic [3:0] addr_r[2];
    logic       rvalid[2];
    logic       busy[2];
    logic       addr_err[2];

    int n_tests = 0;
    int n_fail  = 0;

    int dep[2] = '{16, 12};
    int lat[2] = '{1, 2};
    bit wf[2]  = '{1'b1, 1'b0};

    logic [5:0] mm[2][16];
    bit         pv[2][4];
    logic [5:0] pd[2][4];
    logic [5:0] last[2];
    int         cyc = 0;

    always #5 clk = ~clk;

    ram_2p_param #(
        .DEPTH(16), .WIDTH(6), .RD_LATENCY(1), .WRITE_FIRST(1'b1),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT0)
    ) u0 (
        .clock(clk), .reset_n(reset_n), .write(write[0]),
        .datain(datain[0]), .wmask(wmask[0]), .addr_w(addr_w[0]),
        .read(read[0]), .addr_r(addr_r[0]), .clear(clear[0]),
        .dataout(dataout[0]), .rvalid(rvalid[0]), .busy(busy[0]),
        .addr_err(addr_err[0])
    );

    ram_2p_param #(
        .DEPTH(12), .WIDTH(6), .RD_LATENCY(2), .WRITE_FIRST(1'b0),
        .CLEAR_ON_RESET(1'b0), .INIT_VALUE(INIT1)
    ) u1 (
        .clock(clk), .reset_n(reset_n), .write(write[1]),
        .datain(datain[1]), .wmask(wmask[1]), .addr_w(addr_w[1]),
        .read(read[1]), .addr_r(addr_r[1]), .clear(clear[1]),
        .dataout(dataout[1]), .rvalid(rvalid[1]), .busy(busy[1]),
        .addr_err(addr_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int i, input bit w, input int aw, input int d,
                       input int m, input bit r, input int ar);
        write[i]  = w;
        addr_w[i] = 4'(aw);
        datain[i] = 6'(d);
        wmask[i]  = 6'(m);
        read[i]   = r;
        addr_r[i] = 4'(ar);
        clear[i]  = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) drv(i, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    function automatic logic [5:0] word0(input int k);
        return u0.mem_unit[k*6 +: 6];
    endfunction

    function automatic logic [5:0] word1(input int k);
        return u1.mem_unit[k*6 +: 6];
    endfunction

    // One clock of traffic: update the model at the edge, then compare.
    task automatic tick();
        logic [5:0] old;
        logic [5:0] merged;
        logic [5:0] val;
        bit         e[2];
        bit         exp_rv;
        int         slot;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e[i]   = 1'b0;
            merged = '0;
            old    = mm[i][addr_w[i]];
            if (write[i]) begin
                if (int'(addr_w[i]) < dep[i])
                    merged = (datain[i] & wmask[i]) | (old & ~wmask[i]);
                else
                    e[i] = 1'b1;
            end
            if (read[i]) begin
                if (int'(addr_r[i]) < dep[i]) begin
                    val = mm[i][addr_r[i]];
                    if (wf[i] && write[i] && addr_w[i] == addr_r[i]) val = merged;
                end else begin
                    val  = '0;
                    e[i] = 1'b1;
                end
                slot = (cyc + lat[i] - 1) % 4;
                pv[i][slot] = 1'b1;
                pd[i][slot] = val;
            end
            if (write[i] && int'(addr_w[i]) < dep[i]) mm[i][addr_w[i]] = merged;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            slot   = cyc % 4;
            exp_rv = pv[i][slot];
            if (exp_rv) begin
                last[i]     = pd[i][slot];
                pv[i][slot] = 1'b0;
            end
            check($sformatf("rvalid%0d c%0d", i, cyc), rvalid[i], exp_rv);
            check($sformatf("dataout%0d c%0d", i, cyc), dataout[i], last[i]);
            check($sformatf("addr_err%0d c%0d", i, cyc), addr_err[i], e[i]);
            check($sformatf("busy%0d c%0d", i, cyc), busy[i], 0);
        end
        @(negedge clk);
    endtask

    initial begin
        int nb0;
        int nb1;
        int bad;
        int nb;

        idle_all();
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 4; s++) begin
                pv[i][s] = 1'b0;
                pd[i][s] = '0;
            end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_dout%0d", i), dataout[i], 0);
            check($sformatf("rst_rvalid%0d", i), rvalid[i], 0);
            check($sformatf("rst_err%0d", i), addr_err[i], 0);
        end
        check("rst_busy0", busy[0], 1);
        check("rst_busy1", busy[1], 0);

        // Release reset; hold a write/read on u0 while it clears, start u1 clear.
        reset_n = 1'b1;
        drv(0, 1'b1, 0, 9, 63, 1'b1, 0);
        clear[1] = 1'b1;
        nb0 = 0;
        nb1 = 0;
        bad = 0;
        for (int c = 0; c < 24; c++) begin
            if (busy[0]) nb0++;
            if (busy[1]) nb1++;
            if (busy[0] && (rvalid[0] || addr_err[0])) bad++;
            if (!busy[0]) begin
                write[0] = 1'b0;
                read[0]  = 1'b0;
            end
            @(posedge clk);
            #1;
            clear[1] = 1'b0;
        end
        check("busy_len0", nb0, 16);
        check("busy_len1", nb1, 12);
        check("rd_in_busy", bad, 0);
        @(negedge clk);
        check("mem0_w0", u0.mem_unit[5:0], INIT0);
        check("mem0_w15", u0.mem_unit[95:90], INIT0);
        for (int k = 0; k < 16; k++) check($sformatf("clr0_w%0d", k), word0(k), INIT0);
        for (int k = 0; k < 12; k++) check($sformatf("clr1_w%0d", k), word1(k), INIT1);
        for (int k = 0; k < 16; k++) begin
            mm[0][k] = INIT0;
            mm[1][k] = INIT1;
        end
        last[0] = '0;
        last[1] = '0;

        // Directed writes, masked write and collision.
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 0, 2, 63, 1'b0, 0);
        tick();
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 5, 10, 63, 1'b0, 0);
        tick();
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 5, 11, 3, 1'b0, 0);
        tick();
        check("mask0", word0(5), 11);
        check("mask1", word1(5), 11);
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 5, 10, 63, 1'b0, 0);
        tick();
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 5, 11, 63, 1'b1, 5);
        tick();
        check("coll_wf_dout", dataout[0], 11);
        check("coll_wf_rv", rvalid[0], 1);
        idle_all();
        tick();
        check("coll_rf_dout", dataout[1], 10);
        check("coll_rf_rv", rvalid[1], 1);

        // Back-to-back reads 0, 5, 11.
        for (int i = 0; i < 2; i++) drv(i, 1'b1, 11, 7, 63, 1'b1, 0);
        tick();
        check("lat1_dout", dataout[0], 2);
        for (int i = 0; i < 2; i++) drv(i, 1'b0, 0, 0, 0, 1'b1, 5);
        tick();
        check("b2b_a_dout", dataout[1], 2);
        check("b2b_a_rv", rvalid[1], 1);
        for (int i = 0; i < 2; i++) drv(i, 1'b0, 0, 0, 0, 1'b1, 11);
        tick();
        check("b2b_b_dout", dataout[1], 11);
        check("b2b_b_rv", rvalid[1], 1);
        idle_all();
        tick();
        check("b2b_c_dout", dataout[1], 7);
        check("b2b_c_rv", rvalid[1], 1);

        // Out-of-range write and read on the 12-word instance.
        drv(1, 1'b1, 13, 63, 63, 1'b1, 14);
        tick();
        check("oor_err", addr_err[1], 1);
        idle_all();
        tick();
        check("oor_err_once", addr_err[1], 0);
        check("oor_rv", rvalid[1], 1);
        check("oor_dout", dataout[1], 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                int aw;
                int ar;
                int m;
                aw = int'($urandom_range(0, 15));
                ar = ($urandom_range(0, 3) == 0) ? aw : int'($urandom_range(0, 15));
                m  = ($urandom_range(0, 1) == 1) ? 63 : int'($urandom_range(0, 63));
                drv(i, 1'($urandom_range(0, 1)), aw, int'($urandom_range(0, 63)),
                    m, 1'($urandom_range(0, 1)), ar);
            end
            tick();
        end
        idle_all();
        tick();
        tick();
        for (int k = 0; k < 16; k++) check($sformatf("fin0_w%0d", k), word0(k), mm[0][k]);
        for (int k = 0; k < 12; k++) check($sformatf("fin1_w%0d", k), word1(k), mm[1][k]);

        // Clear restart and reset abort on u0.
        drv(0, 1'b1, 1, 6'h33, 63, 1'b0, 0);
        tick();
        drv(0, 1'b0, 0, 0, 0, 1'b1, 1);
        tick();
        check("pre_clr_dout", dataout[0], 6'h33);
        idle_all();
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        check("clr_busy", busy[0], 1);
        @(negedge clk);
        clear[0] = 1'b0;
        repeat (2) @(negedge clk);
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy[0]) break;
            nb++;
            @(posedge clk);
            #1;
        end
        check("restart_len", nb, 16);
        check("clr_hold_dout", dataout[0], 6'h33);

        @(negedge clk);
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_dout0", dataout[0], 0);
        check("arst_rv0", rvalid[0], 0);
        check("arst_busy0", busy[0], 1);
        check("arst_busy1", busy[1], 0);
        check("arst_dout1", dataout[1], 0);
        @(negedge clk);
        reset_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 24; c++) begin
            if (busy[0]) nb++;
            @(posedge clk);
            #1;
        end
        check("rerst_len", nb, 16);
        check("rerst_w1", word0(1), INIT0);
        check("rerst_w15", word0(15), INIT0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_2p_param.md
Name: ram_2p_param

Overview:
- Parametrised simple dual-port RAM (one write port, one read port, single clock). Successor to the basic 16x6 RAM.
- Adds four features:
  - per-bit write mask;
  - selectable read latency;
  - selectable read-during-write collision mode;
  - a hardware clear engine that fills memory with INIT_VALUE after reset or on request.
- Used as a storage primitive for register files and buffers across the design.

Parameters:
- DEPTH, 16: number of words (any value ≥2, not limited to powers of 2).
- WIDTH, 6: bits per word.
- RD_LATENCY, 1: read latency in clocks. Legal values are 1 and 2.
- WRITE_FIRST, 1: 1 = a same-address read returns the newly written data. 0 = it returns the old data.
- CLEAR_ON_RESET, 1: 1 = start the clear sequence automatically when reset is released.
- INIT_VALUE, 0: WIDTH-bit value written by the clear sequence.
- ADDR_W (localparam) = $clog2(DEPTH), minimum 1.

Ports:
- clock  in  1  Sole clock. All state updates on the rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- write  in  1  Write enable.
- datain  in  WIDTH  Write data.
- wmask  in  WIDTH  Per-bit write mask. 1 = update that bit.
- addr_w  in  ADDR_W  Write address.
- read  in  1  Read request.
- addr_r  in  ADDR_W  Read address.
- clear  in  1  Start the clear sequence.
- dataout  out  WIDTH  Registered read data.
- rvalid  out  1  One-cycle pulse: dataout updated this cycle.
- busy  out  1  Clear sequence in progress.
- addr_err  out  1  One-cycle pulse: an out-of-range address was used.

Behaviour:
- Storage:
  - Held as a flat vector mem_unit[DEPTH*WIDTH-1:0]; word k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH]. Benches probe this hierarchically.
  - Memory contents are not touched by reset itself.
- Reset (reset_n=0, asynchronous):
  - dataout=0, rvalid=0, addr_err=0, read pipeline cleared, clear counter=0.
  - State=CLEAR and busy=1 if CLEAR_ON_RESET, otherwise state=IDLE and busy=0.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on a clock edge with clear=1. busy rises in the same cycle.
  - In CLEAR, each edge writes INIT_VALUE to word cnt, then cnt increments.
  - After word DEPTH-1 is written: cnt=0, state=IDLE, busy=0. A clear therefore takes exactly DEPTH clocks.
  - clear=1 while in CLEAR restarts the sequence at cnt=0.
  - Reset asserted mid-clear aborts the sequence; it then follows the reset rules above.
- While busy=1:
  - write and read are ignored. rvalid stays 0, dataout holds, addr_err stays 0.
- Write (IDLE, write=1, addr_w<DEPTH):
  - For every bit i: mem[addr_w][i] <= wmask[i] ? datain[i] : old value.
  - wmask=0 means no change.
- Read (IDLE, read=1, addr_r<DEPTH):
  - RD_LATENCY=1: dataout and rvalid update at the same edge that samples read.
  - RD_LATENCY=2: one additional register stage; the pipeline accepts back-to-back reads, one per clock.
  - With read=0, dataout holds its last value and rvalid=0.
- Collision (write and read to the same in-range address on the same edge):
  - WRITE_FIRST=1: dataout = merged new word (old bits where wmask=0).
  - WRITE_FIRST=0: dataout = word before the write.
- Out of range (address ≥ DEPTH; only possible when DEPTH is not a power of 2):
  - Such a write is dropped.
  - Such a read returns 0 with rvalid pulsed.
  - addr_err pulses aligned with the cycle the request was sampled, for either port.

Test Plan (DEPTH=16, WIDTH=6 unless stated):
1. Reset release with CLEAR_ON_RESET=1, INIT_VALUE=6'd5 -> busy=1 for exactly 16 clocks. Then mem_unit[5:0]=5 and mem_unit[95:90]=5. A write issued during busy is ignored.
2. Write 2 to addr 0, later read addr 0 -> RD_LATENCY=1: dataout=2 with rvalid one edge after request. RD_LATENCY=2: one edge later. Reads to addrs 0,5,15 back-to-back with RD_LATENCY=2 -> three consecutive rvalid pulses carrying the correct data.
3. Write 10 to addr 5, then write 11 with wmask=6'b000011 -> mem[5]=6'd11 (bits 1:0 from 11, others kept from 10).
4. Same-edge write 11 / read addr 5, with mem[5]=10 -> WRITE_FIRST=1 gives dataout=11; WRITE_FIRST=0 gives dataout=10.
5. clear pulsed at clock 3 of an in-progress clear, then reset_n dropped mid-sequence -> counter restarts at 0 on the clear. After reset, busy is re-evaluated per CLEAR_ON_RESET and dataout=0 immediately (asynchronously).
6. DEPTH=12: write to addr 13 and read addr 14 -> no memory change, dataout=0, rvalid=1, addr_err pulses once.
